// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix output path (feeder and output stage).
package matrix_pkg;

  localparam int SPI_SIZE         = 8;
  localparam int BYTES_PER_MATRIX = 384;
  localparam int BYTES_PER_COLUMN = 24;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    START,
    START_WAIT,
    FETCH,
    LATCH,
    ISSUE,
    DATA_WAIT
  } feeder_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_IMAGE,
    OUT_COLUMN,
    OUT_DATA
  } state_t;

endpackage

// File: rtl/handshake_timer.sv
// Cycle counter for bounded handshake waits: cleared on demand, saturates at its
// terminal count, and flags expiry once TIMEOUT cycles have been spent counting.
module handshake_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] TERMINAL = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TERMINAL);

endmodule

// File: rtl/matrix_frame_feeder.sv
// Reads one frame from the double-buffered frame RAM and hands it byte-by-byte to
// output_module over the new_image / next_data / tx_finish level handshake.
module matrix_frame_feeder #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = matrix_pkg::SPI_SIZE,
  parameter int BYTES_PER_MATRIX = matrix_pkg::BYTES_PER_MATRIX,
  parameter int BYTES_PER_COLUMN = matrix_pkg::BYTES_PER_COLUMN,
  parameter int TIMEOUT          = 1023
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                frame_valid,
  input  logic                                frame_bank,
  output logic                                frame_ack,
  output logic [$clog2(BYTES_PER_MATRIX):0]   rd_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0]  rd_data,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0]  data_out,
  output logic                                new_image,
  output logic                                new_column,
  output logic                                next_data,
  input  logic                                tx_finish,
  output logic                                frame_done,
  output logic                                error
);

  import matrix_pkg::*;

  localparam int IDX_W = $clog2(BYTES_PER_MATRIX);
  localparam int COL_W = (BYTES_PER_COLUMN > 1) ? $clog2(BYTES_PER_COLUMN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_MATRIX - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BYTES_PER_COLUMN - 1);

  feeder_state_t    state;
  logic             bank;
  logic [IDX_W-1:0] byte_idx;
  logic [COL_W-1:0] col_idx;
  logic             timed;
  logic             hs_event;
  logic             timer_expired;
  logic             timeout_hit;

  // hs_event is the tx_finish level that moves a waiting state on; it also
  // restarts the timer so every state gets its own full budget.
  always_comb begin
    timed    = 1'b0;
    hs_event = 1'b0;
    case (state)
      START, ISSUE: begin
        timed    = 1'b1;
        hs_event = !tx_finish;
      end
      START_WAIT, DATA_WAIT: begin
        timed    = 1'b1;
        hs_event = tx_finish;
      end
      default: begin
        timed    = 1'b0;
        hs_event = 1'b0;
      end
    endcase
  end

  handshake_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!timed || hs_event),
    .run     (timed),
    .expired (timer_expired)
  );

  assign timeout_hit = timed && timer_expired && !hs_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank       <= 1'b0;
      byte_idx   <= '0;
      col_idx    <= '0;
      rd_addr    <= '0;
      data_out   <= '0;
      frame_ack  <= 1'b0;
      new_image  <= 1'b0;
      new_column <= 1'b0;
      next_data  <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      frame_ack  <= 1'b0;
      frame_done <= 1'b0;
      if (timeout_hit) begin
        // A stalled output stage abandons the frame; no frame_done is reported.
        error      <= 1'b1;
        new_image  <= 1'b0;
        next_data  <= 1'b0;
        new_column <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (tx_finish) state <= WAIT_FRAME;
          end
          WAIT_FRAME: begin
            if (enable && frame_valid) begin
              frame_ack <= 1'b1;
              bank      <= frame_bank;
              byte_idx  <= '0;
              col_idx   <= '0;
              new_image <= 1'b1;
              state     <= START;
            end
          end
          START: begin
            if (!tx_finish) begin
              new_image <= 1'b0;
              state     <= START_WAIT;
            end
          end
          START_WAIT: begin
            if (tx_finish) begin
              rd_addr <= {bank, byte_idx};
              state   <= FETCH;
            end
          end
          FETCH: begin
            state <= LATCH;
          end
          LATCH: begin
            data_out   <= rd_data;
            next_data  <= 1'b1;
            new_column <= (col_idx == '0) && (byte_idx != '0);
            state      <= ISSUE;
          end
          ISSUE: begin
            if (!tx_finish) begin
              next_data  <= 1'b0;
              new_column <= 1'b0;
              state      <= DATA_WAIT;
            end
          end
          DATA_WAIT: begin
            if (tx_finish) begin
              if (byte_idx == LAST_IDX) begin
                frame_done <= 1'b1;
                state      <= WAIT_FRAME;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                col_idx  <= (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
                rd_addr  <= {bank, byte_idx + 1'b1};
                state    <= FETCH;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/matrix_frame_feeder.md
Name: matrix_frame_feeder

Overview:
- Upstream stage of output_module.
- Reads one matrix frame (BYTES_PER_MATRIX bytes per channel) from the double-buffered frame RAM written by the HDMI capture path.
- Presents the frame byte-by-byte on data_out using the new_image / new_column / next_data / tx_finish handshake.
- Replaces the fixed test-pattern sequencer in the top level.

Parameters:
- CHANNEL_NUMBER, 3, number of parallel SPI channels.
- SPI_SIZE, 8, bits per channel word.
- BYTES_PER_MATRIX, 384, bytes per channel per frame (8x16 RGB).
- BYTES_PER_COLUMN, 24, bytes per matrix column (8 rows x 3 colours).
- TIMEOUT, 1023, max cycles to wait for tx_finish to change before error.

Ports:
- clk  input  1  feeder clock, same clock as output_module.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when low, no new frame is started; the frame in progress completes.
- frame_valid  input  1  a complete frame is available in bank frame_bank.
- frame_bank  input  1  bank holding the ready frame.
- frame_ack  output  1  one-cycle pulse: frame accepted, bank latched.
- rd_addr  output  ADDR_W  frame RAM read address {bank, byte_idx}; ADDR_W = $clog2(BYTES_PER_MATRIX)+1.
- rd_data  input  CHANNEL_NUMBER x SPI_SIZE  RAM read data; one-cycle read latency.
- data_out  output  CHANNEL_NUMBER x SPI_SIZE  word per channel to output_module.
- new_image  output  1  start-of-image command.
- new_column  output  1  start-of-column qualifier; asserted only with next_data.
- next_data  output  1  data word command.
- tx_finish  input  1  output_module idle/ready; falls when a command is accepted.
- frame_done  output  1  one-cycle pulse after the last byte completes.
- error  output  1  sticky handshake-timeout flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; data_out all zeros; state IDLE; byte_idx 0; bank 0.
- Handshake rule: a command (new_image or next_data) is a level, held until tx_finish=0 is sampled. It is deasserted the cycle after. Completion is the next sampled tx_finish=1.
- States:
  - IDLE: wait for tx_finish=1, then go to WAIT_FRAME.
  - WAIT_FRAME: when enable=1 and frame_valid=1, pulse frame_ack, latch bank<=frame_bank, set byte_idx=0, go to START. Otherwise stay.
  - START: new_image=1. On tx_finish=0, go to START_WAIT.
  - START_WAIT: on tx_finish=1, go to FETCH.
  - FETCH: rd_addr={bank, byte_idx}. Go to LATCH next cycle.
  - LATCH: data_out<=rd_data, go to ISSUE.
  - ISSUE: next_data=1. new_column=1 when byte_idx % BYTES_PER_COLUMN == 0 and byte_idx != 0. On tx_finish=0, go to DATA_WAIT.
  - DATA_WAIT: on tx_finish=1:
    - if byte_idx == BYTES_PER_MATRIX-1: pulse frame_done, go to WAIT_FRAME;
    - else byte_idx++, go to FETCH.
- Minimum latency: frame_ack to new_image = 1 cycle. tx_finish rise in DATA_WAIT to next next_data = 3 cycles (FETCH, LATCH, ISSUE).
- data_out is stable for the whole of ISSUE and DATA_WAIT.
- Column counter: a separate modulo-BYTES_PER_COLUMN counter, not a divider. It wraps to 0 on reaching BYTES_PER_COLUMN-1 and resets at frame start.
- frame_valid and enable both low in WAIT_FRAME: outputs idle, no RAM reads.
- frame_valid held high across frames: each frame is accepted with its own frame_ack pulse.
- Timeout: a cycle counter runs in START, START_WAIT, ISSUE and DATA_WAIT. It resets on every state change. On reaching TIMEOUT: error<=1, all commands drop, go to IDLE, discard the frame (no frame_done).
- Reset mid-frame: immediate return to reset values. The next frame starts with new_image.
- rd_addr holds its last value outside FETCH.

Decomposition:
- matrix_pkg holds:
  - feeder_state_t (enum logic [2:0]: IDLE, WAIT_FRAME, START, START_WAIT, FETCH, LATCH, ISSUE, DATA_WAIT);
  - the shared constants SPI_SIZE, BYTES_PER_MATRIX, BYTES_PER_COLUMN;
  - the existing output state_t, moved there.
- One natural sub-module: handshake_timer (load/clear, terminal-count output), reused later by the capture path.

Test Plan:
- Basic frame: BYTES_PER_MATRIX=48, BYTES_PER_COLUMN=24, RAM bank0 byte i = {i, i+1, i+2}. Model accepts each command after 2 cycles and finishes after 5. Required:
  - exactly 1 new_image and 48 next_data;
  - data_out matches RAM in order;
  - new_column only on byte 24;
  - one frame_done.
- Double buffer: frame_valid=1 with bank=1, then bank=0. Required: rd_addr MSB is 1 for the first frame and 0 for the second; two frame_ack pulses.
- Latency: model answers immediately. Required: exactly 3 cycles from tx_finish rising in DATA_WAIT to next_data high. Command drops the cycle after tx_finish=0.
- Timeout: TIMEOUT=15, model never drops tx_finish during new_image. Required: error=1 after 15 cycles, new_image=0, state IDLE, no frame_done.
- Reset mid-frame: assert rst_n=0 at byte 20. Required: all outputs 0 asynchronously. After release, a new frame begins with new_image and byte 0.
- enable=0 during a frame: the current frame completes with all 48 bytes, then no frame_ack until enable=1.
